// File: rtl/uart_rx.sv
// UART receiver: two-flop input synchroniser, OVS-oversampled start/data/stop
// sampling at mid-bit, one-clock rx_done / frame_err pulses.
module uart_rx #(
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] TICK_HALF = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   sync_meta_q;
    logic                   rx_s_q;
    logic                   stop_sample;

    // State register: everything, including the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            sync_meta_q <= 1'b1;
            rx_s_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            sync_meta_q <= rx_line;
            rx_s_q      <= sync_meta_q;
        end
    end

    // Next-state logic; nothing moves between baud ticks.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (baud_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TICK_HALF) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + CW'(1);
                    end
                end
                DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + CW'(1);
                    end
                end
                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign stop_sample = baud_tick && (state_q == STOP) && (tick_q == TICK_LAST);

    // Output logic: pulses and data update are computed here and registered,
    // so busy drops in the same cycle rx_done/frame_err rises.
    always_comb begin
        data_d = data_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        busy_d = (state_d != IDLE);
        if (stop_sample) begin
            if (rx_s_q) begin
                data_d = shift_q;
                done_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign data_out  = data_q;
    assign rx_done   = done_q;
    assign frame_err = err_q;
    assign busy      = busy_q;

endmodule
